alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, default 8, datapath width of operands and result; W >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester i's operation accepted this cycle.
REQ-006 req0_op / req1_op  input  3  opcode: 000 add, 001 shift right, 010 shift left, 011 XOR; 100-111 illegal.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  W  operands.
REQ-008 alu_op  output  3; alu_a, alu_b  output  W  drive the shared ALU.
REQ-009 alu_out  input  W; alu_zero, alu_sign  input  1  combinational ALU results.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumer accepts.
REQ-012 rsp_id  output  1  requester index the response belongs to.
REQ-013 rsp_data  output  W; rsp_zero, rsp_sign, rsp_err  output  1  captured result, flags, illegal-op flag.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; at most one operation in flight.
REQ-015 In IDLE, if any req valid, grant exactly one: the only valid one, or, if both are valid, the one not equal to last_grant.
REQ-016 reqN_ready is combinational: 1 only in IDLE for the granted requester; 0 in EXEC and RESP.
REQ-017 On accept (valid & ready), latch op, a, b and the requester id; update last_grant to that id.
REQ-018 Accept with legal op: IDLE -> EXEC.
REQ-019 Accept with illegal op: IDLE -> RESP; rsp_data=0, rsp_zero=0, rsp_sign=0, rsp_err=1; ALU is not used.
REQ-020 In EXEC (exactly one cycle): ALU inputs come from latched registers; capture alu_out, alu_zero and alu_sign into the response registers with rsp_err=0; EXEC -> RESP.
REQ-021 alu_op, alu_a and alu_b are always driven from the latched operand registers, never directly from requester inputs.
REQ-022 In RESP: rsp_valid=1; response outputs stay stable until rsp_valid & rsp_ready.
REQ-023 When rsp_valid & rsp_ready: RESP -> IDLE; the next accept is possible in the following cycle, giving a throughput of 1 op per 3 cycles minimum.
REQ-024 Latency: accept in cycle k; rsp_valid=1 from cycle k+2 for a legal op, and from cycle k+1 for an illegal op.
REQ-025 rsp_valid=0 in IDLE and EXEC; response outputs hold their last values when rsp_valid=0.
REQ-026 Requester inputs changing while not ready have no effect; a dropped reqN_valid before grant is not an error.
REQ-027 A requester held valid across several rounds is never starved: with both valid continuously, grants alternate 0,1,0,1.
REQ-028 rsp_ready asserted outside RESP is ignored.

Reset
REQ-029 rst_n=0 asynchronously forces: state=IDLE, last_grant=1 (req0 wins first contention), operand/op/id registers=0, response registers=0, rsp_valid=0, req0_ready=req1_ready=0 while reset is asserted.
REQ-030 Reset asserted in EXEC or RESP discards the in-flight operation; no response is produced after release.
REQ-031 The first accept is possible in the first cycle after rst_n deasserts.

Verification
REQ-032 W=8, req0 only, op=000, a=8'h0F, b=8'h01, rsp_ready=1 -> accept cycle k; rsp_valid in k+2 with rsp_id=0, rsp_data=8'h10, rsp_err=0, rsp_zero/rsp_sign equal to the alu_zero/alu_sign captured in EXEC; IDLE in k+3.
REQ-033 Both requesters valid continuously after reset, req0 op=011 a=b=8'hAA, req1 op=010 a=8'h81 -> grants in order 0,1,0,1; req0 rsp_data=8'h00 with rsp_zero captured from alu_zero; req1 rsp_data=8'h02.
REQ-034 req1 op=3'b101 -> accept in cycle k; rsp_valid in k+1, rsp_err=1, rsp_data=0, rsp_id=1; alu_op/alu_a/alu_b unchanged from prior values.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and all response fields stable; both reqN_ready=0; accept resumes the cycle after rsp_ready=1.
REQ-036 rst_n pulsed low during EXEC -> outputs reach reset values immediately without a clock edge; no rsp_valid afterwards; next contention is granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// One operation is in flight at a time, and the grant alternates when both requesters contend.
module alu_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_sign,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_sign,
  output logic         rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           id_q, id_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_sign_q, rsp_sign_d;
  logic           rsp_err_q, rsp_err_d;

  logic           any_valid_s;
  logic           grant_s;
  logic           accept_s;
  logic [2:0]     sel_op_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;
  logic           legal_s;

  // Round-robin arbitration and combinational ready generation
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    if (req0_valid & req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req0_valid) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
    // Readies are forced low while reset is held, even though inputs may toggle.
    accept_s   = rst_n & (state_q == ST_IDLE) & any_valid_s;
    req0_ready = accept_s & ~grant_s;
    req1_ready = accept_s & grant_s;
    if (grant_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
    legal_s = ~sel_op_s[2];
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          last_grant_d = grant_s;
          id_d         = grant_s;
          if (legal_s) begin
            op_d    = sel_op_s;
            a_d     = sel_a_s;
            b_d     = sel_b_s;
            state_d = ST_EXEC;
          end else begin
            // Illegal ops bypass the ALU, so its operand registers keep their old values.
            rsp_id_d   = grant_s;
            rsp_data_d = '0;
            rsp_zero_d = 1'b0;
            rsp_sign_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_id_d   = id_q;
        rsp_data_d = alu_out;
        rsp_zero_d = alu_zero;
        rsp_sign_d = alu_sign;
        rsp_err_d  = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 3'd0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_sign  = rsp_sign_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a combinational ALU model, a transaction-level reference model
// checked every negedge, and directed scenarios with literal expectations.
module tb_alu_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op, alu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out;
  logic         alu_zero, alu_sign;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_sign, rsp_err;
  logic [W-1:0] rsp_data;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_err(rsp_err)
  );

  // Shared ALU: shifts move by one bit position.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a >> 1;
      3'd2:    return a << 1;
      3'd3:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_out == '0);
  assign alu_sign = alu_out[W-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: one outstanding transaction plus the visible response.
  int           m_last;
  bit           m_busy;
  int           m_wait;
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b;
  logic         p_id, p_zero, p_sign, p_err;
  logic [W-1:0] p_data;
  logic         h_id, h_zero, h_sign, h_err;
  logic [W-1:0] h_data;

  int           grant_log[$];
  int           rid_log[$];
  logic [W-1:0] rdata_log[$];
  logic         rzero_log[$];

  always @(negedge clk) begin : compare
    int g;
    logic e0, e1;
    logic [2:0] op;
    logic [W-1:0] a, b, r;
    bit was_idle;
    if (!rst_n) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_alu_a", alu_a, 0);
      m_last = 1; m_busy = 0; m_wait = 0;
      m_op = '0; m_a = '0; m_b = '0;
      h_id = 0; h_data = '0; h_zero = 0; h_sign = 0; h_err = 0;
    end else begin
      g = (req0_valid && req1_valid) ? 1 - m_last : (req0_valid ? 0 : 1);
      e0 = !m_busy && (req0_valid || req1_valid) && (g == 0);
      e1 = !m_busy && (req0_valid || req1_valid) && (g == 1);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("rsp_valid", rsp_valid, m_busy && m_wait == 0);
      chk("rsp_id", rsp_id, h_id);
      chk("rsp_data", rsp_data, h_data);
      chk("rsp_zero", rsp_zero, h_zero);
      chk("rsp_sign", rsp_sign, h_sign);
      chk("rsp_err", rsp_err, h_err);
      chk("alu_op", alu_op, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (req0_ready && req0_valid) grant_log.push_back(0);
      if (req1_ready && req1_valid) grant_log.push_back(1);
      if (rsp_valid && rsp_ready) begin
        rid_log.push_back(int'(rsp_id));
        rdata_log.push_back(rsp_data);
        rzero_log.push_back(rsp_zero);
      end
      // Advance the model across the coming rising edge.
      was_idle = !m_busy;
      if (m_busy) begin
        if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin
            h_id = p_id; h_data = p_data; h_zero = p_zero; h_sign = p_sign; h_err = p_err;
          end
        end else if (rsp_ready) begin
          m_busy = 0;
        end
      end
      if (was_idle && (req0_valid || req1_valid)) begin
        op = (g == 1) ? req1_op : req0_op;
        a  = (g == 1) ? req1_a : req0_a;
        b  = (g == 1) ? req1_b : req0_b;
        m_last = g;
        m_busy = 1;
        p_id = (g == 1);
        if (op < 3'd4) begin
          m_op = op; m_a = a; m_b = b;
          r = alu_fn(op, a, b);
          p_data = r; p_zero = (r == '0); p_sign = r[W-1]; p_err = 0;
          m_wait = 1;
        end else begin
          p_data = '0; p_zero = 0; p_sign = 0; p_err = 1;
          m_wait = 0;
          h_id = p_id; h_data = p_data; h_zero = p_zero; h_sign = p_sign; h_err = p_err;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    grant_log.delete(); rid_log.delete(); rdata_log.delete(); rzero_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h00; req0_b = 8'h00;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;
    #1;
    chk("lit_rst_ready0", req0_ready, 0);
    chk("lit_rst_rsp_valid", rsp_valid, 0);
    req0_valid = 1'b0;
    step(2);
    rst_n = 1'b1;

    // Single add from req0: first accept right after reset release.
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h0F; req0_b = 8'h01;
    #1 chk("lit_add_ready", req0_ready, 1);
    step(1);
    req0_valid = 1'b0;
    #1 chk("lit_add_exec_valid", rsp_valid, 0);
    step(1);
    #1;
    chk("lit_add_valid", rsp_valid, 1);
    chk("lit_add_data", rsp_data, 8'h10);
    chk("lit_add_id", rsp_id, 0);
    chk("lit_add_err", rsp_err, 0);
    chk("lit_add_zero", rsp_zero, 0);
    step(1);
    #1 chk("lit_add_idle", rsp_valid, 0);

    // Continuous contention after a fresh reset.
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    clear_logs();
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 8'hAA; req0_b = 8'hAA;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 8'h81; req1_b = 8'h00;
    step(12);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(1);
    chk("lit_grant_cnt", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("lit_grant0", grant_log[0], 0);
      chk("lit_grant1", grant_log[1], 1);
      chk("lit_grant2", grant_log[2], 0);
      chk("lit_grant3", grant_log[3], 1);
    end
    chk("lit_rsp_cnt", rdata_log.size(), 4);
    if (rdata_log.size() >= 2) begin
      chk("lit_xor_id", rid_log[0], 0);
      chk("lit_xor_data", rdata_log[0], 8'h00);
      chk("lit_xor_zero", rzero_log[0], 1);
      chk("lit_shl_id", rid_log[1], 1);
      chk("lit_shl_data", rdata_log[1], 8'h02);
    end

    // Illegal op from req1: one-cycle response, ALU untouched.
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 8'h55; req1_b = 8'h66;
    #1 chk("lit_ill_ready", req1_ready, 1);
    step(1);
    req1_valid = 1'b0;
    #1;
    chk("lit_ill_valid", rsp_valid, 1);
    chk("lit_ill_err", rsp_err, 1);
    chk("lit_ill_data", rsp_data, 8'h00);
    chk("lit_ill_id", rsp_id, 1);
    chk("lit_ill_alu_op", alu_op, 3'b010);
    chk("lit_ill_alu_a", alu_a, 8'h81);
    chk("lit_ill_alu_b", alu_b, 8'h00);
    step(1);

    // Back-pressure: response held for five cycles.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h7F; req0_b = 8'h01;
    #1 chk("lit_bp_ready", req0_ready, 1);
    step(1);
    req0_valid = 1'b0;
    step(1);
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 8'h12; req0_b = 8'h34;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'h80; req1_b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lit_bp_valid", rsp_valid, 1);
      chk("lit_bp_data", rsp_data, 8'h80);
      chk("lit_bp_sign", rsp_sign, 1);
      chk("lit_bp_ready0", req0_ready, 0);
      chk("lit_bp_ready1", req1_ready, 0);
      step(1);
    end
    rsp_ready = 1'b1;
    #1 chk("lit_bp_release_valid", rsp_valid, 1);
    step(1);
    #1;
    chk("lit_bp_resume_ready1", req1_ready, 1);
    chk("lit_bp_resume_ready0", req0_ready, 0);
    step(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(3);

    // Reset during EXEC discards the op; next contention goes to req0.
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h01; req0_b = 8'h02;
    step(1);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("lit_mid_rst_valid", rsp_valid, 0);
    chk("lit_mid_rst_data", rsp_data, 8'h00);
    chk("lit_mid_rst_alu_a", alu_a, 8'h00);
    chk("lit_mid_rst_alu_op", alu_op, 3'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 3'd1; req0_a = 8'h40; req1_op = 3'd0; req1_a = 8'h03; req1_b = 8'h04;
    #1;
    chk("lit_post_rst_ready0", req0_ready, 1);
    chk("lit_post_rst_ready1", req1_ready, 0);
    step(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
